// File: rtl/psg_mixer_pkg.sv
// Shared widths, register addresses and sample-period phase type for the PSG voice mixer.
package psg_mixer_pkg;

  localparam int VOICE_W = 12;
  localparam int VOL_W   = 8;
  localparam int MVOL_W  = 4;
  localparam int ACC_W   = 24;
  localparam int SCL_W   = 29;
  localparam int OUT_W   = 15;
  localparam int PROD_W  = VOICE_W + VOL_W;

  localparam logic [3:0] ADR_EN   = 4'd14;
  localparam logic [3:0] ADR_MVOL = 4'd15;

  typedef enum logic [1:0] {
    PH_ACC,
    PH_SCALE,
    PH_OUT,
    PH_IDLE
  } phase_t;

endpackage

// File: rtl/psg_mix_scale.sv
// Master-volume scaling, right shift and 15-bit saturation of the accumulated mix.
// Optional clipping is enabled by defining PSG_MIXER_CLIP_EN; otherwise the result wraps.
module psg_mix_scale
  import psg_mixer_pkg::*;
#(
  parameter int pShift = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               scale_en,
  input  logic               out_en,
  input  logic [ACC_W-1:0]   acc,
  input  logic [MVOL_W-1:0]  mvol,
  output logic [OUT_W-1:0]   o,
  output logic               ov
);

  logic [SCL_W-1:0]  scaled;
  logic [MVOL_W:0]   mvol_p1;
  logic [OUT_W-1:0]  sat;

  assign mvol_p1 = {1'b0, mvol} + 5'd1;

`ifdef PSG_MIXER_CLIP_EN
  logic [SCL_W-1:0] shifted;
  assign shifted = scaled >> pShift;
  assign sat = (shifted > SCL_W'(32767)) ? 15'h7FFF : shifted[OUT_W-1:0];
`else
  assign sat = OUT_W'(scaled >> pShift);
`endif

  // o holds between output phases so the filter latch at cnt==0 sees a stable value
  always_ff @(posedge clk) begin
    if (rst) begin
      scaled <= '0;
      o      <= '0;
      ov     <= 1'b0;
    end else begin
      if (scale_en)
        scaled <= SCL_W'(acc) * SCL_W'(mvol_p1);
      if (out_en)
        o <= sat;
      ov <= out_en;
    end
  end

endmodule

// File: rtl/psg_voice_mixer.sv
// Serial multiply-accumulate voice mixer owning the shared sample-phase counter.
// Build option: PSG_MIXER_CLIP_EN selects output clipping instead of wrapping.
module psg_voice_mixer
  import psg_mixer_pkg::*;
#(
  parameter int pVoices = 4,
  parameter int pShift  = 12
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr,
  input  logic [3:0]                 adr,
  input  logic [7:0]                 din,
  input  logic [VOICE_W*pVoices-1:0] v,
  output logic [7:0]                 cnt,
  output logic [OUT_W-1:0]           o,
  output logic                       ov
);

  localparam logic [7:0] NV = 8'(pVoices);

  logic [VOL_W-1:0]   vol [pVoices];
  logic [pVoices-1:0] en;
  logic [MVOL_W-1:0]  mvol;
  logic [ACC_W-1:0]   acc;

  logic [VOICE_W-1:0] cur_v;
  logic [VOL_W-1:0]   cur_vol;
  logic               cur_en;
  logic [PROD_W-1:0]  prod;
  phase_t             phase;

  always_comb begin
    phase = PH_IDLE;
    if (cnt < NV)
      phase = PH_ACC;
    else if (cnt == NV)
      phase = PH_SCALE;
    else if (cnt == NV + 8'd1)
      phase = PH_OUT;
  end

  // voice k is consumed while cnt==k, so the counter itself steers the operand mux
  always_comb begin
    cur_v   = '0;
    cur_vol = '0;
    cur_en  = 1'b0;
    for (int k = 0; k < pVoices; k++) begin
      if (cnt == 8'(k)) begin
        cur_v   = v[k*VOICE_W +: VOICE_W];
        cur_vol = vol[k];
        cur_en  = en[k];
      end
    end
  end

  assign prod = cur_en ? PROD_W'(cur_v) * PROD_W'(cur_vol) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < pVoices; k++)
        vol[k] <= '0;
      en   <= '1;
      mvol <= 4'd15;
    end else if (wr) begin
      for (int k = 0; k < pVoices; k++)
        if (adr == 4'(k))
          vol[k] <= din;
      if (adr == ADR_EN)
        en <= pVoices'(16'(din));
      if (adr == ADR_MVOL)
        mvol <= din[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= cnt + 8'd1;
      if (phase == PH_ACC)
        acc <= ((cnt == 8'd0) ? '0 : acc) + ACC_W'(prod);
    end
  end

  psg_mix_scale #(.pShift(pShift)) u_scale (
    .clk      (clk),
    .rst      (rst),
    .scale_en (phase == PH_SCALE),
    .out_en   (phase == PH_OUT),
    .acc      (acc),
    .mvol     (mvol),
    .o        (o),
    .ov       (ov)
  );

endmodule

// File: doc/psg_voice_mixer.md
Name: psg_voice_mixer

Overview:
Upstream neighbour of the PSG FIR filter. Owns the 8-bit sample-phase counter `cnt` that the filter consumes. Once per 256-clock sample period it serially multiplies each voice sample by its volume and accumulates the products. It then applies master volume, shifts and saturates, and presents a 15-bit unsigned sample `o`. `o` feeds the filter's `i`; the filter latches it at `cnt==0`.

Parameters:
- pVoices, 4, number of voices; legal range 1..14.
- pShift, 12, right-shift applied to the master-scaled sum before output.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- wr  in  1  register write strobe
- adr  in  4  register address
- din  in  8  register write data
- v  in  12*pVoices  packed unsigned voice samples; voice k is v[12k+11:12k]
- cnt  out  8  sample-phase counter, shared with the downstream filter
- o  out  15  mixed unsigned sample
- ov  out  1  one-cycle pulse; `o` updated this cycle

Behaviour:
- One clock; reset is synchronous and active-high (`clk`, `rst`).
- Reset values:
  - cnt=0, acc=0, scaled=0, o=0, ov=0.
  - vol[0..pVoices-1]=0, mvol=15, en=all ones.
- cnt: free-running, +1 every clk, wraps 255->0. First cycle after reset shows cnt=0.
- Register writes (wr=1), applied at the clock edge:
  - adr<pVoices: vol[adr]<=din.
  - adr==14: en<=din[pVoices-1:0], zero-extended when pVoices>8.
  - adr==15: mvol<=din[3:0].
  - All other addresses are ignored.
- Accumulate phase, at the edge where cnt==k and k<pVoices:
  - acc <= (k==0 ? 0 : acc) + (en[k] ? v_k*vol[k] : 0).
  - Product is 20 bits; acc is 24 bits.
  - v_k, vol[k] and en[k] are the values present before that edge.
- Scale phase, at the edge where cnt==pVoices: scaled <= acc*(mvol+1), 29 bits unsigned.
- Output phase, at the edge where cnt==pVoices+1:
  - o <= sat15(scaled>>pShift).
  - ov<=1 for exactly one cycle, visible while cnt==pVoices+2.
- `o` holds at all other times. It is stable across the filter's cnt==0 latch.
- Latency: voice k is sampled at cnt==k; the resulting `o` is visible at cnt==pVoices+2.
- Write racing accumulation: a write to vol[k] on the same edge that consumes vol[k] uses the old value; the new value applies from the next period. No shadow registers.
- rst has priority over wr and over every phase. Reset mid-period discards the partial acc; no ov pulse for that period.
- v is not registered; upstream holds it stable for cnt 0..pVoices-1.

Optional Feature:
- Macro PSG_MIXER_CLIP_EN.
  - Defined: sat15 clamps any shifted value >32767 to 0x7FFF.
  - Undefined: sat15 takes the low 15 bits (wrap) and the comparator is not synthesised.

Decomposition:
- Package psg_mixer_pkg holds:
  - VOICE_W=12, VOL_W=8, MVOL_W=4, ACC_W=24, SCL_W=29, OUT_W=15.
  - ADR_EN=4'd14, ADR_MVOL=4'd15.
- One natural sub-module, psg_mix_scale: (mvol+1) multiply, shift, sat15. Keeps the clip macro local to it.
- Register file, counter and MAC stay in the top module.

Test Plan:
1. Assert rst 3 cycles, then release -> o=0, ov=0, cnt steps 0,1,…,255,0. One ov pulse per period, each time at cnt==6.
2. vol0=0x80, other vols 0, v0=0x800, mvol=15, pShift=12 -> o=0x400 (1024) with ov high at cnt==6. The filter sees 1024 at its next cnt==0.
3. Same setup as 2, then write en=0x0E -> next period o=0. Write en=0x0F -> o returns to 1024.
4. pShift=10, all vol=0xFF, all v=0xFFF, mvol=15 (raw 65264):
   - PSG_MIXER_CLIP_EN defined -> o=0x7FFF.
   - Undefined -> o=32496.
5. rst pulsed while cnt==2 in a period whose expected o is 1024 -> o=0, no ov that period, cnt=0 next cycle. The following full period gives o=1024.
6. From test 2's setup, write vol0=0x40 on the edge where cnt==0 -> current period o=1024; next period o=512. Simultaneous wr and rst -> vol0 stays 0.
